// File: rtl/nios2_mul_seq_pkg.sv
// Shared types for the Nios II multiply sequencer: op encodings, FSM states,
// MULX pass count, per-pass accumulate shifts and the per-pass operand select.
package nios2_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CORR  = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    localparam int NUM_MULX_PASSES = 4;
    localparam int PASS_W          = $clog2(NUM_MULX_PASSES);
    localparam int SHIFT_W         = 6;

    // Partial-product weights: lo*lo, hi*lo, lo*hi, hi*hi.
    localparam logic [NUM_MULX_PASSES-1:0][SHIFT_W-1:0] PASS_SHIFT =
        {6'd32, 6'd16, 6'd16, 6'd0};

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
    } mul_operands_t;

    // p[0] selects the high half of a, p[1] the high half of b.
    function automatic mul_operands_t pass_operands(input logic              mulx,
                                                    input logic [PASS_W-1:0] p,
                                                    input logic [31:0]       a,
                                                    input logic [31:0]       b);
        mul_operands_t o;
        if (!mulx) begin
            o.src1 = a;
            o.src2 = b;
        end else begin
            o.src1 = {16'h0000, p[0] ? a[31:16] : a[15:0]};
            o.src2 = {16'h0000, p[1] ? b[31:16] : b[15:0]};
        end
        return o;
    endfunction

endpackage

// File: rtl/nios2_mul_seq_if.sv
// Request/response handshake plus the multiply-cell operand/result bus.
interface nios2_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] A_mul_src1;
    logic [31:0] A_mul_src2;
    logic [31:0] A_mul_cell_result;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready, A_mul_cell_result,
        output req_ready, rsp_valid, rsp_result, A_mul_src1, A_mul_src2
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready, A_mul_cell_result,
        input  req_ready, rsp_valid, rsp_result, A_mul_src1, A_mul_src2
    );
endinterface

// File: rtl/nios2_mul_seq_acc.sv
// 64-bit shift-accumulate with signed high-word correction (NIOS2_MUL_SEQ_MULX_EN);
// without the macro only a 32-bit result register is built.
module nios2_mul_acc
    import nios2_mul_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr_i,
    input  logic               add_i,
    input  logic               corr_i,
    input  logic               mulx_i,
    input  logic [SHIFT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    input  logic [31:0]        a_i,
    input  logic [31:0]        b_i,
    input  logic [31:0]        prod_i,
    output logic [31:0]        result_o
);

`ifdef NIOS2_MUL_SEQ_MULX_EN
    logic [63:0] acc_q;
    logic [63:0] addend;
    logic [31:0] corr_sub;

    assign addend = {32'h0, prod_i} << shamt_i;

    // Unsigned product to signed: subtract b (resp. a) from the high word per negative operand.
    always_comb begin
        corr_sub = '0;
        case (op_i)
            OP_MULXSU: corr_sub = a_i[31] ? b_i : 32'h0;
            OP_MULXSS: corr_sub = (a_i[31] ? b_i : 32'h0) + (b_i[31] ? a_i : 32'h0);
            default:   corr_sub = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= mulx_i ? (acc_q + addend) : {acc_q[63:32], prod_i};
        end else if (corr_i) begin
            acc_q[63:32] <= acc_q[63:32] - corr_sub;
        end
    end

    assign result_o = mulx_i ? acc_q[63:32] : acc_q[31:0];
`else
    logic [31:0] acc_q;
    logic        ctl_unused;

    assign ctl_unused = ^{corr_i, mulx_i, shamt_i, op_i, a_i, b_i};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= prod_i;
        end
    end

    assign result_o = acc_q;
`endif

endmodule

// File: rtl/nios2_mul_seq.sv
// Multiply sequencer in front of the L-cycle Nios II multiply cell: one pass for MUL,
// four 16x16 passes plus correction for MULX* when NIOS2_MUL_SEQ_MULX_EN is defined.
module nios2_mul_seq
    import nios2_mul_pkg::*;
#(
    parameter int MUL_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    nios2_mul_seq_if.slave bus,
    output logic           busy
);

    localparam int               LAT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MUL_LATENCY - 1);

    seq_state_e         state_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               busy_q;
    logic [31:0]        src1_q;
    logic [31:0]        src2_q;
    logic [LAT_W-1:0]   lat_q;
    logic               req_hs;
    logic               last_wait;
    logic               mulx;
    logic [SHIFT_W-1:0] shamt;
    mul_operands_t      issue_d;

    assign req_hs    = (state_q == S_IDLE) && req_ready_q && bus.req_valid;
    assign last_wait = (state_q == S_WAIT) && (lat_q == LAT_LAST);

`ifdef NIOS2_MUL_SEQ_MULX_EN
    logic [1:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [PASS_W-1:0] p_q;
    logic              mulx_d;
    mul_operands_t     next_pass_d;

    assign mulx_d      = (bus.req_op != OP_MUL);
    assign mulx        = (op_q != OP_MUL);
    assign shamt       = PASS_SHIFT[p_q];
    assign issue_d     = pass_operands(mulx_d, '0, bus.req_src1, bus.req_src2);
    assign next_pass_d = pass_operands(1'b1, p_q + PASS_W'(1), a_q, b_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            p_q  <= '0;
        end else if (req_hs) begin
            op_q <= bus.req_op;
            a_q  <= bus.req_src1;
            b_q  <= bus.req_src2;
            p_q  <= '0;
        end else if (last_wait && mulx) begin
            p_q  <= p_q + PASS_W'(1);
        end
    end

    nios2_mul_acc u_acc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (req_hs),
        .add_i    (last_wait),
        .corr_i   (state_q == S_CORR),
        .mulx_i   (mulx),
        .shamt_i  (shamt),
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .prod_i   (bus.A_mul_cell_result),
        .result_o (bus.rsp_result)
    );
`else
    logic op_unused;

    assign op_unused = ^bus.req_op;
    assign mulx      = 1'b0;
    assign shamt     = '0;
    assign issue_d   = pass_operands(1'b0, '0, bus.req_src1, bus.req_src2);

    nios2_mul_acc u_acc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (req_hs),
        .add_i    (last_wait),
        .corr_i   (1'b0),
        .mulx_i   (mulx),
        .shamt_i  (shamt),
        .op_i     (2'b00),
        .a_i      (32'h0),
        .b_i      (32'h0),
        .prod_i   (bus.A_mul_cell_result),
        .result_o (bus.rsp_result)
    );
`endif

    // Operands are only non-zero during ISSUE; they default to zero every other cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            lat_q       <= '0;
        end else begin
            src1_q <= '0;
            src2_q <= '0;
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_hs) begin
                        req_ready_q      <= 1'b0;
                        busy_q           <= 1'b1;
                        state_q          <= S_ISSUE;
                        {src1_q, src2_q} <= issue_d;
                    end
                end
                S_ISSUE: begin
                    lat_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    lat_q <= lat_q + LAT_W'(1);
                    if (lat_q == LAT_LAST) begin
`ifdef NIOS2_MUL_SEQ_MULX_EN
                        if (mulx && (p_q != PASS_W'(NUM_MULX_PASSES - 1))) begin
                            state_q          <= S_ISSUE;
                            {src1_q, src2_q} <= next_pass_d;
                        end else if (mulx) begin
                            state_q <= S_CORR;
                        end else begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                        end
`else
                        state_q     <= S_DONE;
                        rsp_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef NIOS2_MUL_SEQ_MULX_EN
                S_CORR: begin
                    state_q     <= S_DONE;
                    rsp_valid_q <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.A_mul_src1 = src1_q;
    assign bus.A_mul_src2 = src2_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_nios2_mul_seq.sv
// Scoreboard bench: two sequencers (cell latency 1 and 3), each with a behavioural cell model.
module tb_nios2_mul_seq;
    import nios2_mul_pkg::*;

    localparam int N = 2;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid  [N];
    logic        req_ready  [N];
    logic [1:0]  req_op     [N];
    logic [31:0] req_src1   [N];
    logic [31:0] req_src2   [N];
    logic        rsp_valid  [N];
    logic        rsp_ready  [N];
    logic [31:0] rsp_result [N];
    logic [31:0] mul_src1   [N];
    logic [31:0] mul_src2   [N];
    logic        busy       [N];

    typedef struct {
        logic [31:0] res;
        longint      due;
        int          stall;
    } exp_t;

    exp_t        exp_q [N][$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          in_rsp     [N];
    logic [31:0] held       [N];
    int          stall_left [N];
    exp_t        mon_e;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            localparam int L = (g == 0) ? 1 : 3;
            nios2_mul_seq_if bus ();
            logic [31:0] pipe [L];

            assign bus.req_valid   = req_valid[g];
            assign bus.req_op      = req_op[g];
            assign bus.req_src1    = req_src1[g];
            assign bus.req_src2    = req_src2[g];
            assign bus.rsp_ready   = rsp_ready[g];
            assign req_ready[g]    = bus.req_ready;
            assign rsp_valid[g]    = bus.rsp_valid;
            assign rsp_result[g]   = bus.rsp_result;
            assign mul_src1[g]     = bus.A_mul_src1;
            assign mul_src2[g]     = bus.A_mul_src2;

            always @(posedge clk) begin
                pipe[0] <= bus.A_mul_src1 * bus.A_mul_src2;
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            end
            assign bus.A_mul_cell_result = pipe[L-1];

            nios2_mul_seq #(.MUL_LATENCY(L)) u_dut (
                .clk     (clk),
                .reset_n (reset_n),
                .bus     (bus),
                .busy    (busy[g])
            );
        end
    endgenerate

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 1 : 3;
    endfunction

    function automatic bit is_mulx(input logic [1:0] op);
`ifdef NIOS2_MUL_SEQ_MULX_EN
        return op != 2'b00;
`else
        logic op_unused;
        op_unused = ^op;
        return 1'b0;
`endif
    endfunction

    // Reference: full-precision products from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
`ifdef NIOS2_MUL_SEQ_MULX_EN
        case (op)
            2'b01: return p[63:32];
            2'b10: begin p = 64'(longint'($signed(a)) * longint'({32'h0, b})); return p[63:32]; end
            2'b11: begin p = 64'(longint'($signed(a)) * longint'($signed(b)));  return p[63:32]; end
            default: return p[31:0];
        endcase
`else
        if (is_mulx(op)) return 32'h0;
        return p[31:0];
`endif
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
            2:       return 32'($urandom_range(0, 70000));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit chk_src, output longint t_acc);
        int          waited;
        int          L;
        int          npass;
        logic [31:0] e1;
        logic [31:0] e2;
        waited = 0;
        L      = lat_of(sel);
        t_acc  = -1;
        @(negedge clk);
        req_valid[sel] = 1'b1;
        // Garbage on the bus while busy: it must not be latched.
        while (!req_ready[sel] && waited < 400) begin
            req_op[sel]   = 2'($urandom);
            req_src1[sel] = $urandom;
            req_src2[sel] = $urandom;
            @(negedge clk);
            waited++;
        end
        if (!req_ready[sel]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_timeout inst%0d: req_ready stayed 0 for %0d cycles, expected 1", sel, waited);
            req_valid[sel] = 1'b0;
            return;
        end
        req_op[sel]   = op;
        req_src1[sel] = a;
        req_src2[sel] = b;
        chk($sformatf("no_overlap inst%0d", sel), 64'(exp_q[sel].size()), 64'd0);
        t_acc = cyc;
        exp_q[sel].push_back('{model(op, a, b), cyc + (is_mulx(op) ? 6 + 4 * L : 2 + L), stall});
        @(negedge clk);
        req_valid[sel] = 1'b0;
        if (chk_src) begin
            npass = is_mulx(op) ? 4 : 1;
            for (int k = 0; k < npass; k++) begin
                while (cyc < t_acc + 1 + k * (1 + L)) @(negedge clk);
                if (!is_mulx(op)) begin
                    e1 = a;
                    e2 = b;
                end else begin
                    e1 = (k == 1 || k == 3) ? {16'h0, a[31:16]} : {16'h0, a[15:0]};
                    e2 = (k >= 2)           ? {16'h0, b[31:16]} : {16'h0, b[15:0]};
                end
                chk($sformatf("src1_pass%0d inst%0d", k, sel), 64'(mul_src1[sel]), 64'(e1));
                chk($sformatf("src2_pass%0d inst%0d", k, sel), 64'(mul_src2[sel]), 64'(e2));
                @(negedge clk);
                chk($sformatf("src_idle%0d inst%0d", k, sel), {mul_src1[sel], mul_src2[sel]}, 64'd0);
            end
        end
    endtask

    task automatic wait_drain(input int sel);
        int w;
        w = 0;
        while (exp_q[sel].size() != 0 && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (exp_q[sel].size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain inst%0d: %0d responses outstanding, expected 0", sel, exp_q[sel].size());
            exp_q[sel].delete();
            in_rsp[sel] = 1'b0;
        end
    endtask

    // Monitor: latency of first rsp_valid, stability under stall, result on handshake.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset_n && rsp_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp inst%0d: rsp_valid=1 with result 0x%0h, expected no response", i, rsp_result[i]);
                    rsp_ready[i] = 1'b1;
                end else begin
                    if (!in_rsp[i]) begin
                        in_rsp[i]     = 1'b1;
                        held[i]       = rsp_result[i];
                        stall_left[i] = exp_q[i][0].stall;
                        chk($sformatf("rsp_latency inst%0d", i), 64'(cyc), 64'(exp_q[i][0].due));
                    end else begin
                        chk($sformatf("rsp_hold inst%0d", i), 64'(rsp_result[i]), 64'(held[i]));
                        chk($sformatf("req_ready_in_done inst%0d", i), 64'(req_ready[i]), 64'd0);
                    end
                    if (stall_left[i] > 0) begin
                        rsp_ready[i] = 1'b0;
                        stall_left[i]--;
                    end else begin
                        rsp_ready[i] = 1'b1;
                        mon_e        = exp_q[i].pop_front();
                        in_rsp[i]    = 1'b0;
                        chk($sformatf("rsp_result inst%0d", i), 64'(rsp_result[i]), 64'(mon_e.res));
                    end
                end
            end else begin
                rsp_ready[i] = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t;
        longint target;
        logic [1:0] op;
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b0;
            req_op[i]     = 2'b00;
            req_src1[i]   = '0;
            req_src2[i]   = '0;
            rsp_ready[i]  = 1'b1;
            in_rsp[i]     = 1'b0;
            stall_left[i] = 0;
            held[i]       = '0;
        end
        #2;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset_outputs inst%0d", i),
                64'({rsp_valid[i], rsp_result[i], req_ready[i], busy[i]}), 64'd0);
            chk($sformatf("reset_src inst%0d", i), {mul_src1[i], mul_src2[i]}, 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("post_reset_ready inst%0d", i), 64'({req_ready[i], busy[i]}), 64'b10);
        end

        for (int sel = 0; sel < N; sel++) begin
            issue(sel, 2'b00, 32'h0001_2345, 32'h0000_0010, 0, 1'b1, t);
            issue(sel, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, t);
            issue(sel, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0, t);
            issue(sel, 2'b11, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b0, t);
            issue(sel, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, t);
            issue(sel, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, t);
            issue(sel, 2'b00, $urandom, $urandom, 5, 1'b0, t);
            issue(sel, 2'b10, 32'h8765_4321, 32'h1234_5678, 5, 1'b1, t);
            for (int n = 0; n < 25; n++) begin
                op = 2'($urandom);
                issue(sel, op, rnd_operand(), rnd_operand(), $urandom_range(0, 3), 1'b0, t);
            end
            wait_drain(sel);
        end

        // Asynchronous reset in the middle of an operation: no response may follow.
        issue(0, 2'b11, 32'hDEAD_BEEF, 32'h8000_0001, 0, 1'b0, t);
        target = is_mulx(2'b11) ? t + 1 + 2 * (1 + lat_of(0)) : t + 2;
        while (cyc < target) @(negedge clk);
        #1 reset_n = 1'b0;
        exp_q[0].delete();
        in_rsp[0] = 1'b0;
        #1;
        chk("midop_reset_outputs", 64'({rsp_valid[0], rsp_result[0], req_ready[0], busy[0]}), 64'd0);
        chk("midop_reset_src", {mul_src1[0], mul_src2[0]}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(0, 2'b00, 32'd3, 32'd5, 0, 1'b0, t);
        wait_drain(0);
        wait_drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
